preg_free_list: RTL
===================

// Module: preg_free_list
// PURPOSE
//  Bitmap free list of physical registers for the rename stage. Offers one free preg per cycle,
//  chosen by a priority_decoder instance (highest index wins), and takes back stale pregs at ROB commit.
//  Keeps a committed-state copy of the map so a branch-mispredict flush restores it in one cycle.
//  Sits between ROB commit (free side) and rename (alloc side).
// PARAMETERS
//  NUM_PREGS  128  physical registers; power of two; p0 is hard-wired to x0 and never allocated or freed
//  NUM_AREGS  32   architectural registers; p0..p(NUM_AREGS-1) hold the reset mapping
//  PW         $clog2(NUM_PREGS)  preg index width (localparam, derived)
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        synchronous, active-high reset
//  alloc_valid     out  1        a free preg is offered this cycle
//  alloc_preg      out  PW       offered preg; valid only when alloc_valid=1
//  alloc_en        in   1        rename takes the offered preg; ignored unless alloc_valid=1
//  commit_en       in   1        ROB retires one instruction that has a destination
//  commit_new_preg in   PW       preg that is now architectural (committed as in-use)
//  commit_old_preg in   PW       stale preg released by this commit
//  flush           in   1        mispredict recovery: free map := committed map
//  free_count      out  PW+1     number of set bits in free_map (combinational popcount)
//  err_double_free out  1        sticky: a preg was freed while already free
// BEHAVIOUR
//  - State: free_map[NUM_PREGS] and retire_map[NUM_PREGS]; bit = 1 means free.
//  - Reset: both maps = 1 for indices >= NUM_AREGS and 0 below. err_double_free = 0.
//    After reset: alloc_valid = 1, alloc_preg = NUM_PREGS-1, free_count = NUM_PREGS-NUM_AREGS.
//  - Offer: alloc_valid / alloc_preg come combinationally from the registered free_map, through the
//    priority decoder (highest set index; valid = |free_map). No path from alloc_en to the outputs.
//  - Alloc fires when alloc_valid & alloc_en & !flush. Next cycle free_map[alloc_preg] = 0.
//    Zero-latency offer; one alloc per cycle.
//  - Commit (commit_en=1), all in the same edge:
//    - retire_map[commit_new_preg] <= 0
//    - retire_map[commit_old_preg] <= 1 and free_map[commit_old_preg] <= 1
//    - if commit_old_preg == 0, both updates to index 0 are suppressed (p0 is never freed)
//  - Double free: commit_en & old_preg != 0 & free_map[old_preg] already 1
//    -> err_double_free <= 1, held until reset; the map update still happens.
//  - Flush: free_map <= retire_map as updated by any same-cycle commit (commit is applied first).
//    alloc_en is ignored in a flush cycle; retire_map is unaffected by flush.
//  - Alloc and commit in the same cycle:
//    - different indices: both apply
//    - alloc_preg == commit_old_preg cannot occur when the map is consistent; if it does, free wins
//      (bit ends at 1) and err_double_free is set
//  - Empty map: alloc_valid = 0 and alloc_preg is don't-care. Rename must stall.
//    A commit makes the freed preg visible on the next cycle.
//  - Reset has priority over flush, commit and alloc. Asserting reset mid-operation returns both maps
//    to the reset image on the next edge.
// STRUCTURE
//  - Shared package rename_pkg: NUM_PREGS, NUM_AREGS, typedef logic [PW-1:0] preg_t.
//  - Sub-module: priority_decoder #(.WIDTH(NUM_PREGS)), instantiated unchanged with in = free_map.
//  - Popcount is a local function; the rest is a single always_ff plus next-state always_comb.
// TESTING
//  1. Reset -> alloc_valid=1, alloc_preg=127, free_count=96; then alloc_en for 96 cycles -> grants
//     127 down to 32 in order, then alloc_valid=0 and free_count=0.
//  2. Empty map, commit old=40 new=127 -> next cycle alloc_valid=1, alloc_preg=40, free_count=1.
//  3. Alloc 127,126,125; commit new=127 old=5; flush -> free_map = reset image minus 127, plus 5;
//     alloc_preg=126, free_count=96.
//  4. Flush with alloc_en=1 in the same cycle -> no bit cleared; offer after flush is unchanged.
//  5. Commit old=0 -> map unchanged, err_double_free stays 0.
//     Commit old=100 while bit 100 is free -> err_double_free=1, stays 1 until reset.
//  6. Random alloc/commit/flush against a scoreboard model for 10k cycles, reset asserted mid-run
//     -> outputs match the model every cycle.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and the physical register index type.
// The reset image marks every preg above the architectural set as free.
package rename_pkg;
  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;
  localparam int PW        = $clog2(NUM_PREGS);

  typedef logic [PW-1:0]        preg_t;
  typedef logic [NUM_PREGS-1:0] preg_map_t;

  localparam preg_map_t RESET_FREE_MAP = {NUM_PREGS{1'b1}} << NUM_AREGS;
endpackage

// File: rtl/preg_free_list_if.sv
// Rename/commit bundle between the pipeline (master) and the free list (slave).
// Offer signals flow slave->master; alloc_en, commit and flush flow master->slave.
interface preg_free_list_if;
  import rename_pkg::*;

  logic         alloc_valid;
  preg_t        alloc_preg;
  logic         alloc_en;
  logic         commit_en;
  preg_t        commit_new_preg;
  preg_t        commit_old_preg;
  logic         flush;
  logic [PW:0]  free_count;
  logic         err_double_free;

  modport master (
    input  alloc_valid, alloc_preg, free_count, err_double_free,
    output alloc_en, commit_en, commit_new_preg, commit_old_preg, flush
  );

  modport slave (
    output alloc_valid, alloc_preg, free_count, err_double_free,
    input  alloc_en, commit_en, commit_new_preg, commit_old_preg, flush
  );
endinterface

// File: rtl/priority_decoder.sv
// Combinational highest-set-index finder; valid is the OR of all inputs.
// Zero latency, no flow control.
module priority_decoder #(
  parameter int WIDTH = 128,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic             valid,
  output logic [IW-1:0]    idx
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Ascending scan so the last (highest) set bit overwrites earlier ones.
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/preg_free_list.sv
// Bitmap preg free list: zero-latency offer of the highest free preg, frees at commit,
// one-cycle flush restore from the committed map. Rename stalls when alloc_valid is low.
module preg_free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  preg_free_list_if.slave     fl
);
  preg_map_t free_map_q, free_map_d;
  preg_map_t retire_map_q, retire_map_d;
  logic      err_double_free_q, err_double_free_d;
  logic      offer_vld;
  preg_t     offer_preg;
  logic      alloc_fire;

  function automatic logic [PW:0] popcount(input preg_map_t m);
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < NUM_PREGS; i++) c = c + (PW+1)'(m[i]);
    return c;
  endfunction

  priority_decoder #(.WIDTH(NUM_PREGS)) u_prio (
    .in    (free_map_q),
    .valid (offer_vld),
    .idx   (offer_preg)
  );

  assign fl.alloc_valid     = offer_vld;
  assign fl.alloc_preg      = offer_preg;
  assign fl.free_count      = popcount(free_map_q);
  assign fl.err_double_free = err_double_free_q;

  assign alloc_fire = offer_vld & fl.alloc_en & ~fl.flush;

  always_comb begin
    free_map_d        = free_map_q;
    retire_map_d      = retire_map_q;
    err_double_free_d = err_double_free_q;

    if (alloc_fire) free_map_d[offer_preg] = 1'b0;

    // Free is applied after alloc so a colliding index ends up free.
    if (fl.commit_en) begin
      retire_map_d[fl.commit_new_preg] = 1'b0;
      if (fl.commit_old_preg != '0) begin
        if (free_map_q[fl.commit_old_preg]) err_double_free_d = 1'b1;
        retire_map_d[fl.commit_old_preg] = 1'b1;
        free_map_d[fl.commit_old_preg]   = 1'b1;
      end
    end

    if (fl.flush) free_map_d = retire_map_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_map_q        <= RESET_FREE_MAP;
      retire_map_q      <= RESET_FREE_MAP;
      err_double_free_q <= 1'b0;
    end else begin
      free_map_q        <= free_map_d;
      retire_map_q      <= retire_map_d;
      err_double_free_q <= err_double_free_d;
    end
  end
endmodule
